instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 15 +
 rtl/ifetch_queue.sv | 67 ++++++
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: widths, prefetch depth and fetch FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int QDEPTH  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/ifetch_queue.sv
// Prefetch FIFO of {instr, pc} pairs with synchronous flush and a combinational head.
// Latency: a push is visible at the head on the edge after it is written.
// Backpressure: none internally; the caller never pushes into a full queue.
module ifetch_queue #(
    parameter int DEPTH   = cpu_pkg::QDEPTH,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int PC_W    = cpu_pkg::PC_W,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [INSTR_W-1:0] push_instr_i,
    input  logic [PC_W-1:0]    push_pc_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [CNT_W-1:0]   count_o,
    output logic [INSTR_W-1:0] head_instr_o,
    output logic [PC_W-1:0]    head_pc_o
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; flush wins over any push/pop on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= '{instr: push_instr_i, pc: push_pc_i};
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign count_o      = count_q;
    // Head reads as zero when empty so stale entries never leak out after a flush.
    assign head_instr_o = (count_q != '0) ? mem_q[rd_ptr_q].instr : '0;
    assign head_pc_o    = (count_q != '0) ? mem_q[rd_ptr_q].pc    : '0;

endmodule : ifetch_queue

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential prefetch from sync RAM into a small queue, with redirect/halt flush.
// Latency: start/redirect at edge N -> read in cycle N+1 -> ir_valid after edge N+2; one instr/cycle steady state.
// Backpressure: ir_ack low stops reads once queued + in-flight entries fill the queue.
module instr_fetch #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int QDEPTH  = cpu_pkg::QDEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PC_W-1:0]    start_pc,
    input  logic               halt,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               ir_ack,
    output logic [PC_W-1:0]    ram_r_addr,
    output logic               ram_re,
    input  logic [INSTR_W-1:0] ram_r_data,
    output logic [INSTR_W-1:0] ir,
    output logic [PC_W-1:0]    ir_pc,
    output logic               ir_valid,
    output logic               busy
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(QDEPTH + 1);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]  q_count;
    logic [INSTR_W-1:0] q_instr;
    logic [PC_W-1:0]   q_pc;

    logic running;
    logic start_idle;
    logic halt_run;
    logic redir_run;
    logic flush;
    logic pop;
    logic push;
    logic issue;

    assign running    = (state_q == RUN);
    assign start_idle = !running && start;
    assign halt_run   = running && halt;
    assign redir_run  = running && redirect && !halt;
    assign flush      = start_idle || halt_run || redir_run;

    assign ir_valid = (q_count != '0);
    // A redirect or halt discards the head, so the consumer's ack is not honoured then.
    assign pop      = ir_ack && ir_valid && !halt_run && !redir_run;
    // The response to last cycle's read lands now unless this cycle flushes.
    assign push     = inflight_q && !flush;

    // Issue while a slot is guaranteed; an entry leaving this cycle frees its slot
    // early, which is what lets a held ir_ack stream one instruction per cycle.
    always_comb begin
        issue = 1'b0;
        if (running && !halt && !redirect) begin
            issue = (int'(q_count) + int'(inflight_q)) < (QDEPTH + int'(pop));
        end
    end

    // Next-state for FSM, fetch pointer and the single in-flight read slot.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        if (start_idle) begin
            state_d = RUN;
            pc_d    = start_pc;
        end else if (halt_run) begin
            state_d = IDLE;
        end else if (redir_run) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // State registers; reset abandons any outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    ifetch_queue #(
        .DEPTH   (QDEPTH),
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_instr_i (ram_r_data),
        .push_pc_i    (inflight_pc_q),
        .pop_i        (pop),
        .flush_i      (flush),
        .count_o      (q_count),
        .head_instr_o (q_instr),
        .head_pc_o    (q_pc)
    );

    assign ram_r_addr = pc_q;
    assign ram_re     = issue;
    assign ir         = q_instr;
    assign ir_pc      = q_pc;
    assign busy       = running;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with an external synchronous RAM model.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [PC_W-1:0]    start_pc = '0;
    logic               halt = 1'b0;
    logic               redirect = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic               ir_ack = 1'b0;
    logic [PC_W-1:0]    ram_r_addr;
    logic               ram_re;
    logic [INSTR_W-1:0] ram_r_data = '0;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    ir_pc;
    logic               ir_valid;
    logic               busy;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir_ack      (ir_ack),
        .ram_r_addr  (ram_r_addr),
        .ram_re      (ram_re),
        .ram_r_data  (ram_r_data),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: data appears the cycle after the read strobe.
    logic [INSTR_W-1:0] rom [2**PC_W];
    always @(posedge clk) begin
        if (ram_re) ram_r_data <= rom[ram_r_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: after a start/redirect to P the consumer must see P, P+1, ...
    // (mod 2^PC_W) with each word equal to the RAM contents; reads go out in the
    // same order and never more than QDEPTH ahead of consumption.
    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } exp_t;

    exp_t            sb[$];
    logic [PC_W-1:0] sb_next;
    logic [PC_W-1:0] exp_fetch = '0;
    int              issued = 0;
    int              consumed = 0;
    int              pops = 0;
    bit              model_idle = 1'b1;

    task automatic refill();
        while (sb.size() < 16) begin
            sb.push_back('{pc: sb_next, instr: rom[sb_next]});
            sb_next = sb_next + 1'b1;
        end
    endtask

    task automatic model_start(input logic [PC_W-1:0] p);
        sb.delete();
        sb_next    = p;
        exp_fetch  = p;
        issued     = 0;
        consumed   = 0;
        model_idle = 1'b0;
        refill();
    endtask

    // Monitor: samples mid-cycle, compares against the model, then applies this cycle's control.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            model_idle = 1'b1;
            issued     = 0;
            consumed   = 0;
        end else begin
            if (model_idle) begin
                check("idle_busy",  32'(busy),     32'd0);
                check("idle_valid", 32'(ir_valid), 32'd0);
                check("idle_re",    32'(ram_re),   32'd0);
            end else begin
                exp_t e;
                check("busy",       32'(busy),       32'd1);
                check("fetch_addr", 32'(ram_r_addr), 32'(exp_fetch));
                if (ir_valid) begin
                    e = sb[0];
                    check("head_pc",    32'(ir_pc), 32'(e.pc));
                    check("head_instr", 32'(ir),    32'(e.instr));
                end
                if (halt || redirect) begin
                    check("re_on_flush", 32'(ram_re), 32'd0);
                end else begin
                    if (ir_valid && ir_ack) begin
                        void'(sb.pop_front());
                        consumed++;
                        pops++;
                        refill();
                    end
                    if (ram_re) begin
                        issued++;
                        exp_fetch = exp_fetch + 1'b1;
                        check("no_overflow", 32'((issued - consumed) <= QDEPTH), 32'd1);
                    end
                end
            end
            if (model_idle && start) begin
                model_start(start_pc);
            end else if (!model_idle && halt) begin
                sb.delete();
                model_idle = 1'b1;
            end else if (!model_idle && redirect) begin
                model_start(redirect_pc);
            end
        end
    end

    // Inputs change only just after a rising edge; directed checks happen just after a falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [PC_W-1:0] p);
        start_pc = p;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ir"},       32'(ir),         32'd0);
        check({tag, "_ir_pc"},    32'(ir_pc),      32'd0);
        check({tag, "_ir_valid"}, 32'(ir_valid),   32'd0);
        check({tag, "_ram_re"},   32'(ram_re),     32'd0);
        check({tag, "_addr"},     32'(ram_r_addr), 32'd0);
        check({tag, "_busy"},     32'(busy),       32'd0);
    endtask

    task automatic check_latency(input string tag, input logic [PC_W-1:0] p);
        samp();
        check({tag, "_re"},     32'(ram_re),     32'd1);
        check({tag, "_addr"},   32'(ram_r_addr), 32'(p));
        check({tag, "_v_n1"},   32'(ir_valid),   32'd0);
        tick();
        samp();
        check({tag, "_v_n2"},   32'(ir_valid),   32'd0);
        tick();
        samp();
        check({tag, "_v_n3"},   32'(ir_valid),   32'd1);
        check({tag, "_pc"},     32'(ir_pc),      32'(p));
    endtask

    initial begin
        logic [PC_W-1:0] wrap_exp [4];
        int p0;
        int budget;

        for (int i = 0; i < 2**PC_W; i++) rom[i] = INSTR_W'($urandom);

        // Reset state.
        #1;
        check_reset_outputs("rst");
        repeat (2) tick();
        rst = 1'b0;

        // Redirect while idle must be ignored.
        redirect_pc = 8'h55;
        redirect    = 1'b1;
        tick();
        redirect = 1'b0;
        samp();
        check("idle_redir_busy", 32'(busy),       32'd0);
        check("idle_redir_addr", 32'(ram_r_addr), 32'd0);

        // Stream from 0x10 with ack held high.
        tick();
        ir_ack = 1'b1;
        pulse_start(8'h10);
        check_latency("start", 8'h10);
        p0 = pops;
        repeat (8) samp();
        check("throughput", 32'(pops - p0), 32'd8);

        // Backpressure: no ack leaves two entries queued and reads stopped.
        tick();
        halt   = 1'b1;
        ir_ack = 1'b0;
        tick();
        halt = 1'b0;
        pulse_start(8'h10);
        repeat (5) tick();
        samp();
        check("bp_valid", 32'(ir_valid), 32'd1);
        check("bp_head",  32'(ir_pc),    32'h10);
        check("bp_re",    32'(ram_re),   32'd0);
        tick();
        ir_ack = 1'b1;
        samp();
        check("bp_refill_re",   32'(ram_re),     32'd1);
        check("bp_refill_addr", 32'(ram_r_addr), 32'h12);
        tick();
        ir_ack = 1'b0;
        samp();
        check("bp_next_head", 32'(ir_pc), 32'h11);
        repeat (3) tick();
        samp();
        check("bp_hold_re",   32'(ram_re), 32'd0);
        check("bp_hold_head", 32'(ir_pc),  32'h11);

        // Redirect with ack in the same cycle.
        tick();
        ir_ack = 1'b1;
        repeat (4) tick();
        samp();
        check("pre_redir_valid", 32'(ir_valid), 32'd1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        check_latency("redir", 8'h40);

        // Wrap around the top of the address space.
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        samp();
        check("halt_busy", 32'(busy), 32'd0);
        tick();
        pulse_start(8'hFE);
        wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        tick();
        tick();
        samp();
        check("wrap_pc0", 32'(ir_pc), 32'(wrap_exp[0]));
        for (int i = 1; i < 4; i++) begin
            tick();
            samp();
            check($sformatf("wrap_pc%0d", i), 32'(ir_pc), 32'(wrap_exp[i]));
        end

        // Halt and redirect together: halt wins, pc is not reloaded.
        tick();
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'h99;
        tick();
        halt     = 1'b0;
        redirect = 1'b0;
        samp();
        check("hr_busy",  32'(busy),       32'd0);
        check("hr_valid", 32'(ir_valid),   32'd0);
        check("hr_addr",  32'(ram_r_addr), 32'(exp_fetch));

        // Random traffic checked by the scoreboard.
        for (int n = 0; n < 600; n++) begin
            int r;
            tick();
            start    = 1'b0;
            halt     = 1'b0;
            redirect = 1'b0;
            ir_ack   = ($urandom_range(0, 3) != 0);
            r        = $urandom_range(0, 99);
            if (model_idle) begin
                if (r < 30) begin
                    start_pc = PC_W'($urandom);
                    start    = 1'b1;
                end
            end else if (r < 3) begin
                halt = 1'b1;
                if (r == 0) redirect = 1'b1;
            end else if (r < 9) begin
                redirect_pc = PC_W'($urandom);
                redirect    = 1'b1;
            end
        end
        tick();
        start    = 1'b0;
        halt     = 1'b0;
        redirect = 1'b0;

        // Reset mid-run with a read outstanding.
        halt = 1'b1;
        tick();
        halt   = 1'b0;
        ir_ack = 1'b1;
        pulse_start(8'h20);
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        samp();
        check("post_rst_valid", 32'(ir_valid), 32'd0);
        tick();
        pulse_start(8'h30);
        budget = 10;
        samp();
        while (!ir_valid && budget > 0) begin
            tick();
            samp();
            budget--;
        end
        check("restart_valid", 32'(ir_valid), 32'd1);
        check("restart_pc",    32'(ir_pc),    32'h30);

        tick();
        ir_ack = 1'b0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch
